// File: rtl/jtag_tap_multi_if.sv
// Pin-side and core-side signal bundle for jtag_tap_multi.
// Latency: none (wires only).
// Backpressure: none; every signal is paced by tck and has no flow control.
//
// master modport: the pin and core driver side (tms, tdi, user_capture).
// slave modport:  the TAP itself.
// tck and trst are not in this bundle; they stay plain ports on the TAP.
interface jtag_tap_multi_if #(
    parameter int IR_LEN = 4,
    parameter int N_USER = 2,
    parameter int USER_W = 32
);
    logic                       tms;
    logic                       tdi;
    logic                       tdo;
    logic                       tdo_en;
    logic [3:0]                 tap_state;
    logic [IR_LEN-1:0]          ir_out;
    logic [N_USER*USER_W-1:0]   user_capture;
    logic [N_USER*USER_W-1:0]   user_data;
    logic [N_USER-1:0]          user_update;
    logic [N_USER-1:0]          user_sel;

    modport master (
        output tms, tdi, user_capture,
        input  tdo, tdo_en, tap_state, ir_out, user_data, user_update, user_sel
    );

    modport slave (
        input  tms, tdi, user_capture,
        output tdo, tdo_en, tap_state, ir_out, user_data, user_update, user_sel
    );
endinterface

// File: rtl/jtag_tap_multi.sv
// JTAG TAP: 16-state controller, IR, BYPASS, optional IDCODE, N_USER user DRs.
// Latency: ir_out/user_data load on the UP_IR/UP_DR edge; tdo is combinational.
// Backpressure: none; the serial protocol is paced entirely by tck/tms.
//
// Ports: tck (TAP clock), trst (async reset, active-high), jtag (slave modport):
//   tms/tdi in, tdo/tdo_en out, tap_state, ir_out, user_capture in,
//   user_data/user_update/user_sel out. Channel k is at [k*USER_W +: USER_W].
// Macro TAP_IDCODE_EN: adds the IDCODE instruction (opcode 1) and 32-bit register,
//   which also becomes the reset instruction. Without it, opcode 1 is BYPASS and
//   the reset instruction is all-ones.
module jtag_tap_multi #(
    parameter int          IR_LEN     = 4,
    parameter int          N_USER     = 2,
    parameter int          USER_W     = 32,
    parameter int          USER_BASE  = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic            tck,
    input  logic            trst,
    jtag_tap_multi_if.slave jtag
);

    typedef enum logic [3:0] {
        TLR    = 4'd0,  IDLE   = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR  = 4'd4,  EX1_DR = 4'd5,  PA_DR  = 4'd6,  EX2_DR = 4'd7,
        UP_DR  = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
        EX1_IR = 4'd12, PA_IR  = 4'd13, EX2_IR = 4'd14, UP_IR  = 4'd15
    } state_t;

`ifdef TAP_IDCODE_EN
    localparam logic [IR_LEN-1:0] RESET_IR = IR_LEN'(1);
`else
    localparam logic [IR_LEN-1:0] RESET_IR = '1;
`endif

    state_t state, state_nxt;

    logic [IR_LEN-1:0]          ir_sr;
    logic [IR_LEN-1:0]          ir_q;
    logic                       bypass_sr;
    logic [USER_W-1:0]          user_sr [N_USER];
    logic [N_USER*USER_W-1:0]   user_data_q;
    logic [N_USER-1:0]          user_update_q;
    logic [N_USER-1:0]          sel_user;
    logic                       sel_byp;
    logic                       tdo_mux;

`ifdef TAP_IDCODE_EN
    logic [31:0]                id_sr;
    logic                       sel_id;
`else
    logic                       unused_idcode;
    assign unused_idcode = ^IDCODE_VAL;
`endif

    // ---------------- controller ----------------
    always_ff @(posedge tck or posedge trst) begin
        if (trst) state <= TLR;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TLR:     state_nxt = jtag.tms ? TLR    : IDLE;
            IDLE:    state_nxt = jtag.tms ? SEL_DR : IDLE;
            SEL_DR:  state_nxt = jtag.tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_nxt = jtag.tms ? EX1_DR : SH_DR;
            SH_DR:   state_nxt = jtag.tms ? EX1_DR : SH_DR;
            EX1_DR:  state_nxt = jtag.tms ? UP_DR  : PA_DR;
            PA_DR:   state_nxt = jtag.tms ? EX2_DR : PA_DR;
            EX2_DR:  state_nxt = jtag.tms ? UP_DR  : SH_DR;
            UP_DR:   state_nxt = jtag.tms ? SEL_DR : IDLE;
            SEL_IR:  state_nxt = jtag.tms ? TLR    : CAP_IR;
            CAP_IR:  state_nxt = jtag.tms ? EX1_IR : SH_IR;
            SH_IR:   state_nxt = jtag.tms ? EX1_IR : SH_IR;
            EX1_IR:  state_nxt = jtag.tms ? UP_IR  : PA_IR;
            PA_IR:   state_nxt = jtag.tms ? EX2_IR : PA_IR;
            EX2_IR:  state_nxt = jtag.tms ? UP_IR  : SH_IR;
            UP_IR:   state_nxt = jtag.tms ? SEL_DR : IDLE;
            default: state_nxt = TLR;
        endcase
    end

    // ---------------- instruction register ----------------
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            ir_sr <= '0;
            ir_q  <= RESET_IR;
        end else begin
            if (state == CAP_IR)
                ir_sr <= IR_LEN'(2'b01);
            else if (state == SH_IR)
                ir_sr <= {jtag.tdi, ir_sr[IR_LEN-1:1]};

            // TLR keeps forcing the reset instruction so a stuck-high tms
            // always lands on a known DR selection.
            if (state == TLR)
                ir_q <= RESET_IR;
            else if (state == UP_IR)
                ir_q <= ir_sr;
        end
    end

    // Any opcode that is not IDCODE or a user channel falls back to BYPASS.
    always_comb begin
        sel_user = '0;
        for (int k = 0; k < N_USER; k++)
            if (ir_q == IR_LEN'(USER_BASE + k)) sel_user[k] = 1'b1;
    end

`ifdef TAP_IDCODE_EN
    assign sel_id  = (ir_q == IR_LEN'(1));
    assign sel_byp = ~(|sel_user) & ~sel_id;
`else
    assign sel_byp = ~(|sel_user);
`endif

    // ---------------- data registers ----------------
    // Only the selected register captures/shifts; the others hold, so a
    // Pause/Exit2 detour leaves everything untouched.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            bypass_sr <= 1'b0;
            for (int k = 0; k < N_USER; k++) user_sr[k] <= '0;
`ifdef TAP_IDCODE_EN
            id_sr     <= '0;
`endif
        end else if (state == CAP_DR) begin
            if (sel_byp) bypass_sr <= 1'b0;
`ifdef TAP_IDCODE_EN
            if (sel_id)  id_sr <= IDCODE_VAL;
`endif
            for (int k = 0; k < N_USER; k++)
                if (sel_user[k]) user_sr[k] <= jtag.user_capture[k*USER_W +: USER_W];
        end else if (state == SH_DR) begin
            if (sel_byp) bypass_sr <= jtag.tdi;
`ifdef TAP_IDCODE_EN
            if (sel_id)  id_sr <= {jtag.tdi, id_sr[31:1]};
`endif
            for (int k = 0; k < N_USER; k++)
                if (sel_user[k]) begin
                    if (USER_W == 1) user_sr[k] <= jtag.tdi;
                    else             user_sr[k] <= {jtag.tdi, user_sr[k][USER_W-1:1]};
                end
        end
    end

    // ---------------- user update ----------------
    // user_update is registered, so it is high for the cycle after UP_DR.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            user_data_q   <= '0;
            user_update_q <= '0;
        end else begin
            user_update_q <= '0;
            if (state == UP_DR) begin
                for (int k = 0; k < N_USER; k++)
                    if (sel_user[k]) begin
                        user_data_q[k*USER_W +: USER_W] <= user_sr[k];
                        user_update_q[k]                <= 1'b1;
                    end
            end
        end
    end

    // ---------------- tdo ----------------
    always_comb begin
        tdo_mux = 1'b0;
        if (state == SH_IR) begin
            tdo_mux = ir_sr[0];
        end else if (state == SH_DR) begin
            if (sel_byp) tdo_mux = bypass_sr;
`ifdef TAP_IDCODE_EN
            if (sel_id)  tdo_mux = id_sr[0];
`endif
            for (int k = 0; k < N_USER; k++)
                if (sel_user[k]) tdo_mux = user_sr[k][0];
        end
    end

    assign jtag.tdo         = tdo_mux;
    assign jtag.tdo_en      = (state == SH_IR) || (state == SH_DR);
    assign jtag.tap_state   = state;
    assign jtag.ir_out      = ir_q;
    assign jtag.user_data   = user_data_q;
    assign jtag.user_update = user_update_q;
    assign jtag.user_sel    = sel_user;

endmodule

// File: tb/tb_jtag_tap_multi.sv
// Testbench for jtag_tap_multi: scenario tasks with a word-level scoreboard.
// Latency: expectations are taken one tck after the UP_* edge that commits them.
// Backpressure: none; the bench paces tms/tdi itself.
module tb_jtag_tap_multi;

    localparam int          IR_LEN     = 4;
    localparam int          N_USER     = 2;
    localparam int          USER_W     = 32;
    localparam int          USER_BASE  = 8;
    localparam logic [31:0] IDCODE_VAL = 32'h1000_0001;
`ifdef TAP_IDCODE_EN
    localparam logic [3:0]  RESET_IR   = 4'h1;
`else
    localparam logic [3:0]  RESET_IR   = 4'hF;
`endif

    logic tck;
    logic trst;

    jtag_tap_multi_if #(.IR_LEN(IR_LEN), .N_USER(N_USER), .USER_W(USER_W)) jtag ();

    jtag_tap_multi #(
        .IR_LEN(IR_LEN), .N_USER(N_USER), .USER_W(USER_W),
        .USER_BASE(USER_BASE), .IDCODE_VAL(IDCODE_VAL)
    ) dut (
        .tck  (tck),
        .trst (trst),
        .jtag (jtag)
    );

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [63:0]   exp_q [$];
    logic [63:0]   model_ud;
    logic [63:0]   tdo_cap;
    logic          en_seen;
    logic [63:0]   exp;

    // -------- stimulus helpers (no comparisons inside) --------
    task automatic step(input logic t, input logic d);
        jtag.tms = t;
        jtag.tdi = d;
        @(posedge tck);
        #1;
    endtask

    // From IDLE or TLR: program the IR, finish back in IDLE. tdo bits of the
    // IR scan land in tdo_cap[IR_LEN-1:0].
    task automatic load_ir(input logic [3:0] v);
        if (jtag.tap_state == 4'd0) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < IR_LEN; i++) begin
            tdo_cap[i] = jtag.tdo;
            step(i == IR_LEN - 1, v[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // From IDLE to SH_DR.
    task automatic enter_dr();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // Shift cnt bits starting at index first; optionally exit on the last.
    task automatic shift_bits(input logic [63:0] din, input int first,
                              input int cnt, input bit exit_last);
        for (int i = first; i < first + cnt; i++) begin
            tdo_cap[i] = jtag.tdo;
            en_seen    = en_seen & jtag.tdo_en;
            step(exit_last && (i == first + cnt - 1), din[i]);
        end
    endtask

    function automatic logic [63:0] pop_exp();
        if (exp_q.size() == 0) return 64'hDEAD_DEAD_DEAD_DEAD;
        return exp_q.pop_front();
    endfunction

    // -------- scenarios --------
    task automatic test_reset();
        trst = 1'b1;
        jtag.tms = 1'b1;
        jtag.tdi = 1'b0;
        jtag.user_capture = '0;
        model_ud = '0;
        #12;
        n_checks++;
        if (jtag.tap_state !== 4'd0) begin
            n_fail++; $display("FAIL reset_async_state got=%0d want=0", jtag.tap_state);
        end
        trst = 1'b0;
        repeat (5) step(1'b1, 1'b0);
        n_checks++;
        if (jtag.tap_state !== 4'd0) begin
            n_fail++; $display("FAIL reset_state got=%0d want=0", jtag.tap_state);
        end
        n_checks++;
        if (jtag.ir_out !== RESET_IR) begin
            n_fail++; $display("FAIL reset_ir got=%h want=%h", jtag.ir_out, RESET_IR);
        end
        n_checks++;
        if ({jtag.tdo, jtag.tdo_en} !== 2'b00) begin
            n_fail++; $display("FAIL reset_tdo got=%b want=00", {jtag.tdo, jtag.tdo_en});
        end
        n_checks++;
        if (jtag.user_data !== model_ud || jtag.user_update !== 2'b00 || jtag.user_sel !== 2'b00) begin
            n_fail++; $display("FAIL reset_user got data=%h upd=%b sel=%b want 0", jtag.user_data, jtag.user_update, jtag.user_sel);
        end
    endtask

`ifdef TAP_IDCODE_EN
    task automatic test_idcode();
        tdo_cap = '0;
        en_seen = 1'b1;
        step(1'b0, 1'b0);
        enter_dr();
        exp_q.push_back({32'h0, IDCODE_VAL});
        shift_bits(64'h0, 0, 32, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        exp = pop_exp();
        n_checks++;
        if (tdo_cap[31:0] !== exp[31:0]) begin
            n_fail++; $display("FAIL idcode_tdo got=%h want=%h", tdo_cap[31:0], exp[31:0]);
        end
        n_checks++;
        if (en_seen !== 1'b1 || jtag.user_update !== 2'b00) begin
            n_fail++; $display("FAIL idcode_side got en=%b upd=%b want en=1 upd=00", en_seen, jtag.user_update);
        end
    endtask
`else
    task automatic test_opcode1_bypass();
        logic [63:0] din;
        din = 64'h3;
        load_ir(4'h1);
        n_checks++;
        if (jtag.ir_out !== 4'h1 || jtag.user_sel !== 2'b00) begin
            n_fail++; $display("FAIL op1_ir got ir=%h sel=%b want ir=1 sel=00", jtag.ir_out, jtag.user_sel);
        end
        tdo_cap = '0;
        enter_dr();
        exp_q.push_back({60'h0, din[2:0], 1'b0});
        shift_bits(din, 0, 4, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        exp = pop_exp();
        n_checks++;
        if (tdo_cap[3:0] !== exp[3:0]) begin
            n_fail++; $display("FAIL op1_bypass_tdo got=%b want=%b", tdo_cap[3:0], exp[3:0]);
        end
    endtask
`endif

    task automatic test_user0();
        logic [63:0] din;
        din = 64'h1234_5678;
        jtag.user_capture = {32'h0BAD_BEEF, 32'hCAFE_F00D};
        load_ir(4'd8);
        n_checks++;
        if (jtag.ir_out !== 4'd8 || jtag.user_sel !== 2'b01) begin
            n_fail++; $display("FAIL u0_ir got ir=%h sel=%b want ir=8 sel=01", jtag.ir_out, jtag.user_sel);
        end
        tdo_cap = '0;
        enter_dr();
        exp_q.push_back({32'h0, 32'hCAFE_F00D});
        model_ud[31:0] = din[31:0];
        shift_bits(din, 0, 32, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        exp = pop_exp();
        n_checks++;
        if (tdo_cap[31:0] !== exp[31:0]) begin
            n_fail++; $display("FAIL u0_tdo got=%h want=%h", tdo_cap[31:0], exp[31:0]);
        end
        n_checks++;
        if (jtag.user_data !== model_ud || jtag.user_update !== 2'b01) begin
            n_fail++; $display("FAIL u0_update got data=%h upd=%b want data=%h upd=01", jtag.user_data, jtag.user_update, model_ud);
        end
        step(1'b0, 1'b0);
        n_checks++;
        if (jtag.user_update !== 2'b00) begin
            n_fail++; $display("FAIL u0_pulse_width got=%b want=00", jtag.user_update);
        end
    endtask

    task automatic test_ir_bypass();
        logic [63:0] din;
        din = 64'h5;
        tdo_cap = '0;
        exp_q.push_back(64'h1);
        load_ir(4'hF);
        exp = pop_exp();
        n_checks++;
        if (tdo_cap[3:0] !== exp[3:0]) begin
            n_fail++; $display("FAIL ir_capture_tdo got=%b want=%b", tdo_cap[3:0], exp[3:0]);
        end
        n_checks++;
        if (jtag.ir_out !== 4'hF || jtag.user_sel !== 2'b00) begin
            n_fail++; $display("FAIL byp_ir got ir=%h sel=%b want ir=f sel=00", jtag.ir_out, jtag.user_sel);
        end
        tdo_cap = '0;
        enter_dr();
        exp_q.push_back({60'h0, din[2:0], 1'b0});
        shift_bits(din, 0, 4, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        exp = pop_exp();
        n_checks++;
        if (tdo_cap[3:0] !== exp[3:0]) begin
            n_fail++; $display("FAIL byp_tdo got=%b want=%b", tdo_cap[3:0], exp[3:0]);
        end
        n_checks++;
        if (jtag.user_update !== 2'b00 || jtag.user_data !== model_ud) begin
            n_fail++; $display("FAIL byp_no_update got upd=%b data=%h want upd=00 data=%h", jtag.user_update, jtag.user_data, model_ud);
        end
    endtask

    task automatic test_unused_opcode();
        logic [63:0] din;
        din = 64'h6;
        load_ir(4'h3);
        n_checks++;
        if (jtag.user_sel !== 2'b00) begin
            n_fail++; $display("FAIL op3_sel got=%b want=00", jtag.user_sel);
        end
        tdo_cap = '0;
        enter_dr();
        exp_q.push_back({61'h0, din[1:0], 1'b0});
        shift_bits(din, 0, 3, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        exp = pop_exp();
        n_checks++;
        if (tdo_cap[2:0] !== exp[2:0]) begin
            n_fail++; $display("FAIL op3_bypass_tdo got=%b want=%b", tdo_cap[2:0], exp[2:0]);
        end
    endtask

    task automatic test_user1_pause();
        logic [63:0] din;
        din = 64'hA5C3_0F96;
        load_ir(4'd9);
        n_checks++;
        if (jtag.user_sel !== 2'b10) begin
            n_fail++; $display("FAIL u1_sel got=%b want=10", jtag.user_sel);
        end
        tdo_cap = '0;
        enter_dr();
        exp_q.push_back({32'h0, jtag.user_capture[63:32]});
        model_ud[63:32] = din[31:0];
        shift_bits(din, 0, 16, 1'b1);
        step(1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b1);
        n_checks++;
        if (jtag.tap_state !== 4'd6 || jtag.user_update !== 2'b00) begin
            n_fail++; $display("FAIL u1_pause got state=%0d upd=%b want state=6 upd=00", jtag.tap_state, jtag.user_update);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        shift_bits(din, 16, 16, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        exp = pop_exp();
        n_checks++;
        if (tdo_cap[31:0] !== exp[31:0]) begin
            n_fail++; $display("FAIL u1_tdo got=%h want=%h", tdo_cap[31:0], exp[31:0]);
        end
        n_checks++;
        if (jtag.user_data !== model_ud || jtag.user_update !== 2'b10) begin
            n_fail++; $display("FAIL u1_update got data=%h upd=%b want data=%h upd=10", jtag.user_data, jtag.user_update, model_ud);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] da;
        logic [63:0] db;
        da = 64'h0F0F_3C3C;
        db = 64'h8765_4321;
        load_ir(4'd8);
        enter_dr();
        model_ud[31:0] = da[31:0];
        shift_bits(da, 0, 32, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_checks++;
        if (jtag.user_data !== model_ud || jtag.user_update !== 2'b01) begin
            n_fail++; $display("FAIL b2b_first got data=%h upd=%b want data=%h upd=01", jtag.user_data, jtag.user_update, model_ud);
        end
        jtag.user_capture[31:0] = 32'h5555_AAAA;
        step(1'b0, 1'b0);
        n_checks++;
        if (jtag.user_update !== 2'b00) begin
            n_fail++; $display("FAIL b2b_gap got=%b want=00", jtag.user_update);
        end
        step(1'b0, 1'b0);
        tdo_cap = '0;
        exp_q.push_back({32'h0, 32'h5555_AAAA});
        model_ud[31:0] = db[31:0];
        shift_bits(db, 0, 32, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        exp = pop_exp();
        n_checks++;
        if (tdo_cap[31:0] !== exp[31:0]) begin
            n_fail++; $display("FAIL b2b_tdo got=%h want=%h", tdo_cap[31:0], exp[31:0]);
        end
        n_checks++;
        if (jtag.user_data !== model_ud || jtag.user_update !== 2'b01) begin
            n_fail++; $display("FAIL b2b_second got data=%h upd=%b want data=%h upd=01", jtag.user_data, jtag.user_update, model_ud);
        end
    endtask

    task automatic test_trst_midshift();
        logic [63:0] din;
        din = 64'hFFFF_FFFF;
        load_ir(4'd8);
        enter_dr();
        shift_bits(din, 0, 16, 1'b0);
        trst = 1'b1;
        model_ud = '0;
        #2;
        n_checks++;
        if (jtag.tap_state !== 4'd0 || jtag.ir_out !== RESET_IR) begin
            n_fail++; $display("FAIL trst_state got state=%0d ir=%h want state=0 ir=%h", jtag.tap_state, jtag.ir_out, RESET_IR);
        end
        n_checks++;
        if (jtag.user_data !== model_ud || jtag.user_update !== 2'b00 || jtag.tdo_en !== 1'b0) begin
            n_fail++; $display("FAIL trst_user got data=%h upd=%b en=%b want 0", jtag.user_data, jtag.user_update, jtag.tdo_en);
        end
        @(posedge tck);
        #1;
        trst = 1'b0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_checks++;
        if (jtag.user_update !== 2'b00 || jtag.user_data !== model_ud || jtag.tap_state !== 4'd0) begin
            n_fail++; $display("FAIL trst_after got upd=%b data=%h state=%0d want upd=00 data=0 state=0", jtag.user_update, jtag.user_data, jtag.tap_state);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        trst = 1'b1;
        jtag.tms = 1'b1;
        jtag.tdi = 1'b0;
        jtag.user_capture = '0;
        tdo_cap = '0;
        en_seen = 1'b1;
        test_reset();
`ifdef TAP_IDCODE_EN
        test_idcode();
`else
        test_opcode1_bypass();
`endif
        test_user0();
        test_ir_bypass();
        test_unused_opcode();
        test_user1_pause();
        test_back_to_back();
        test_trst_midshift();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
